multiplier_seq_param: RTL and testbench

//  Parametrised sequential shift-add multiplier, WIDTH x WIDTH -> 2*WIDTH product held in A:B plus sign/carry bit X.

---
 rtl/multiplier_seq_param_if.sv | 25 ++
 rtl/multiplier_seq_param.sv | 146 ++++++++++++++
 tb/tb_multiplier_seq_param.sv | 295 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/multiplier_seq_param_if.sv
// Operand/result bundle for the sequential shift-add multiplier.
// master drives the controls and operand; slave is the multiplier itself.
interface multiplier_seq_param_if #(
  parameter int unsigned WIDTH = 8
) ();
  logic             ClearA_loadB;
  logic             Execute;
  logic             Signed_mode;
  logic [WIDTH-1:0] Din;
  logic [WIDTH-1:0] Aval;
  logic [WIDTH-1:0] Bval;
  logic             X;
  logic             Busy;
  logic             Done;

  modport master (
    output ClearA_loadB, Execute, Signed_mode, Din,
    input  Aval, Bval, X, Busy, Done
  );

  modport slave (
    input  ClearA_loadB, Execute, Signed_mode, Din,
    output Aval, Bval, X, Busy, Done
  );
endinterface

// File: rtl/multiplier_seq_param.sv
// Sequential shift-add WIDTH x WIDTH multiplier, product in {A,B} with sign/carry bit X.
// Define MULT_FUSED_STEP_EN to merge the add and shift phases into a single STEP state.
module multiplier_seq_param #(
  parameter int unsigned WIDTH = 8
) (
  input logic                     Clk,
  input logic                     Reset,
  multiplier_seq_param_if.slave   bus_io
);

  localparam int unsigned CntW = $clog2(WIDTH + 1);

`ifdef MULT_FUSED_STEP_EN
  typedef enum logic [1:0] {StIdle, StStep, StDone} state_e;
`else
  typedef enum logic [1:0] {StIdle, StAdd, StShift, StDone} state_e;
`endif

  state_e            state_q, state_d;
  logic [WIDTH-1:0]  a_q, a_d;
  logic [WIDTH-1:0]  b_q, b_d;
  logic [WIDTH-1:0]  s_q, s_d;
  logic              x_q, x_d;
  logic              sgn_q, sgn_d;
  logic [CntW-1:0]   cnt_q, cnt_d;

  logic [WIDTH:0]    ext_a, ext_s, sum;
  logic [WIDTH-1:0]  add_a, sh_src_a, sh_a, sh_b;
  logic              add_x, sh_src_x, sh_x;
  logic [CntW-1:0]   cnt_inc;

  // Datapath: conditional add/subtract of S into A, then one-bit right shift of {X,A,B}.
  always_comb begin
    ext_a = sgn_q ? {a_q[WIDTH-1], a_q} : {1'b0, a_q};
    ext_s = sgn_q ? {s_q[WIDTH-1], s_q} : {1'b0, s_q};
    // The top multiplier bit carries negative weight in two's complement.
    if (sgn_q && (cnt_q == CntW'(WIDTH - 1))) begin
      sum = ext_a - ext_s;
    end else begin
      sum = ext_a + ext_s;
    end
    add_a = b_q[0] ? sum[WIDTH-1:0] : a_q;
    add_x = b_q[0] ? sum[WIDTH]     : x_q;
`ifdef MULT_FUSED_STEP_EN
    sh_src_a = add_a;
    sh_src_x = add_x;
`else
    sh_src_a = a_q;
    sh_src_x = x_q;
`endif
    sh_a    = {sh_src_x, sh_src_a[WIDTH-1:1]};
    sh_b    = {sh_src_a[0], b_q[WIDTH-1:1]};
    sh_x    = sgn_q & sh_src_x;
    cnt_inc = cnt_q + CntW'(1);
  end

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    s_d     = s_q;
    x_d     = x_q;
    sgn_d   = sgn_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      StIdle: begin
        if (bus_io.ClearA_loadB) begin
          a_d = '0;
          x_d = 1'b0;
          b_d = bus_io.Din;
        end else if (bus_io.Execute) begin
          s_d   = bus_io.Din;
          sgn_d = bus_io.Signed_mode;
          a_d   = '0;
          x_d   = 1'b0;
          cnt_d = '0;
`ifdef MULT_FUSED_STEP_EN
          state_d = StStep;
`else
          state_d = StAdd;
`endif
        end
      end
`ifdef MULT_FUSED_STEP_EN
      StStep: begin
        a_d     = sh_a;
        b_d     = sh_b;
        x_d     = sh_x;
        cnt_d   = cnt_inc;
        state_d = (cnt_inc == CntW'(WIDTH)) ? StDone : StStep;
      end
`else
      StAdd: begin
        a_d     = add_a;
        x_d     = add_x;
        state_d = StShift;
      end
      StShift: begin
        a_d     = sh_a;
        b_d     = sh_b;
        x_d     = sh_x;
        cnt_d   = cnt_inc;
        state_d = (cnt_inc == CntW'(WIDTH)) ? StDone : StAdd;
      end
`endif
      StDone: begin
        // One multiply per press: wait for Execute to drop before re-arming.
        if (!bus_io.Execute) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      state_q <= StIdle;
      a_q     <= '0;
      b_q     <= '0;
      s_q     <= '0;
      x_q     <= 1'b0;
      sgn_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      s_q     <= s_d;
      x_q     <= x_d;
      sgn_q   <= sgn_d;
      cnt_q   <= cnt_d;
    end
  end

  assign bus_io.Aval = a_q;
  assign bus_io.Bval = b_q;
  assign bus_io.X    = x_q;
  assign bus_io.Done = (state_q == StDone);
`ifdef MULT_FUSED_STEP_EN
  assign bus_io.Busy = (state_q == StStep);
`else
  assign bus_io.Busy = (state_q == StAdd) || (state_q == StShift);
`endif

endmodule

// File: tb/tb_multiplier_seq_param.sv
// Self-checking bench for multiplier_seq_param: WIDTH=8 and WIDTH=16 instances,
// directed and random multiplies compared against plain integer arithmetic.
module tb_multiplier_seq_param;

`ifdef MULT_FUSED_STEP_EN
  localparam int Lat8   = 9;
  localparam int Busy8  = 8;
  localparam int Lat16  = 17;
`else
  localparam int Lat8   = 17;
  localparam int Busy8  = 16;
  localparam int Lat16  = 33;
`endif

  logic Clk   = 1'b0;
  logic Reset = 1'b0;
  always #5 Clk = ~Clk;

  multiplier_seq_param_if #(.WIDTH(8))  bus8  ();
  multiplier_seq_param_if #(.WIDTH(16)) bus16 ();

  multiplier_seq_param #(.WIDTH(8)) u_dut8 (
    .Clk    (Clk),
    .Reset  (Reset),
    .bus_io (bus8)
  );

  multiplier_seq_param #(.WIDTH(16)) u_dut16 (
    .Clk    (Clk),
    .Reset  (Reset),
    .bus_io (bus16)
  );

  int checks = 0;
  int errors = 0;
  logic [7:0] mb8;  // expected contents of register B in the 8-bit instance

  // Integer product of two w-bit operands, reduced to 2*w bits.
  function automatic longint ref_prod(input int w, input longint b, input longint s,
                                      input bit sgn);
    longint p;
    if (sgn && b[w-1]) b = b - (longint'(1) << w);
    if (sgn && s[w-1]) s = s - (longint'(1) << w);
    p = b * s;
    return p & ((longint'(1) << (2 * w)) - 1);
  endfunction

  task automatic load8(input logic [7:0] v);
    @(negedge Clk);
    bus8.ClearA_loadB = 1'b1;
    bus8.Din          = v;
    @(negedge Clk);
    bus8.ClearA_loadB = 1'b0;
    mb8 = v;
  endtask

  // Start one multiply, scramble the other inputs while busy, stop at Done (bounded).
  task automatic run8(input logic [7:0] din, input logic sgn, output logic [7:0] a,
                      output logic [7:0] b, output logic x, output logic done,
                      output int edges, output int busy_n);
    @(negedge Clk);
    bus8.Din         = din;
    bus8.Signed_mode = sgn;
    bus8.Execute     = 1'b1;
    edges  = 0;
    busy_n = 0;
    done   = 1'b0;
    while (!done && edges < 100) begin
      @(posedge Clk);
      #1;
      edges++;
      busy_n += int'(bus8.Busy);
      done = bus8.Done;
      bus8.Din          = 8'($urandom);
      bus8.ClearA_loadB = 1'($urandom);
      bus8.Signed_mode  = 1'($urandom);
    end
    a = bus8.Aval;
    b = bus8.Bval;
    x = bus8.X;
  endtask

  task automatic release8();
    @(negedge Clk);
    bus8.Execute      = 1'b0;
    bus8.ClearA_loadB = 1'b0;
    @(negedge Clk);
  endtask

  task automatic test_reset();
    #2;
    checks++; if (bus8.Aval !== 8'h00) begin errors++; $display("FAIL reset_a got %h want 00", bus8.Aval); end
    checks++; if (bus8.Bval !== 8'h00) begin errors++; $display("FAIL reset_b got %h want 00", bus8.Bval); end
    checks++; if (bus8.X !== 1'b0) begin errors++; $display("FAIL reset_x got %b want 0", bus8.X); end
    checks++; if (bus8.Busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", bus8.Busy); end
    checks++; if (bus8.Done !== 1'b0) begin errors++; $display("FAIL reset_done got %b want 0", bus8.Done); end
    checks++; if ({bus16.Aval, bus16.Bval} !== 32'h0) begin
      errors++; $display("FAIL reset_ab16 got %h want 0", {bus16.Aval, bus16.Bval});
    end
    @(negedge Clk);
    Reset = 1'b1;
    mb8 = 8'h00;
  endtask

  task automatic test_directed();
    bit         ld [4] = '{1'b1, 1'b0, 1'b1, 1'b1};
    logic [7:0] vb [4] = '{8'hFD, 8'h00, 8'h80, 8'hFF};
    logic [7:0] vs [4] = '{8'h07, 8'h02, 8'h80, 8'hFF};
    logic       sg [4] = '{1'b1, 1'b1, 1'b1, 1'b0};
    logic [7:0] ea [4] = '{8'hFF, 8'hFF, 8'h40, 8'hFE};
    logic [7:0] eb [4] = '{8'hEB, 8'hD6, 8'h00, 8'h01};
    logic       ex [4] = '{1'b1, 1'b1, 1'b0, 1'b0};
    logic [7:0] a, b;
    logic x, done;
    int edges, busy_n;
    for (int i = 0; i < 4; i++) begin
      if (ld[i]) load8(vb[i]);
      run8(vs[i], sg[i], a, b, x, done, edges, busy_n);
      checks++; if (a !== ea[i]) begin errors++; $display("FAIL dir%0d_a got %h want %h", i, a, ea[i]); end
      checks++; if (b !== eb[i]) begin errors++; $display("FAIL dir%0d_b got %h want %h", i, b, eb[i]); end
      checks++; if (x !== ex[i]) begin errors++; $display("FAIL dir%0d_x got %b want %b", i, x, ex[i]); end
      checks++; if (done !== 1'b1) begin errors++; $display("FAIL dir%0d_done got %b want 1", i, done); end
      checks++; if (edges != Lat8) begin errors++; $display("FAIL dir%0d_latency got %0d want %0d", i, edges, Lat8); end
      checks++; if (busy_n != Busy8) begin errors++; $display("FAIL dir%0d_busy got %0d want %0d", i, busy_n, Busy8); end
      mb8 = eb[i];
      release8();
    end
  endtask

  task automatic test_random();
    logic [7:0] corner [4] = '{8'h80, 8'h7F, 8'hFF, 8'h00};
    logic [7:0] a, b, din;
    logic x, done, sgn;
    logic [15:0] exp;
    int edges, busy_n;
    for (int i = 0; i < 24; i++) begin
      if (i < 8) load8(corner[i % 4]);
      else if ($urandom_range(0, 2) != 0) load8(8'($urandom));
      din = (i < 8) ? corner[(i / 2) % 4] : 8'($urandom);
      sgn = (i < 8) ? 1'(i) : 1'($urandom);
      exp = 16'(ref_prod(8, longint'(mb8), longint'(din), sgn));
      run8(din, sgn, a, b, x, done, edges, busy_n);
      checks++; if ({a, b} !== exp || done !== 1'b1) begin
        errors++; $display("FAIL rand%0d_prod got %h done %b want %h (b=%h s=%h sgn=%b)",
                           i, {a, b}, done, exp, mb8, din, sgn);
      end
      checks++; if (x !== (sgn & exp[15])) begin
        errors++; $display("FAIL rand%0d_x got %b want %b", i, x, sgn & exp[15]);
      end
      mb8 = exp[7:0];
      release8();
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0] a, b, din;
    logic x, done, sgn;
    logic [15:0] exp;
    int edges, busy_n;
    load8(8'($urandom));
    for (int i = 0; i < 3; i++) begin
      din = 8'($urandom);
      sgn = 1'($urandom);
      exp = 16'(ref_prod(8, longint'(mb8), longint'(din), sgn));
      run8(din, sgn, a, b, x, done, edges, busy_n);
      checks++; if ({a, b} !== exp) begin
        errors++; $display("FAIL b2b%0d_prod got %h want %h", i, {a, b}, exp);
      end
      // Execute still held: no rerun, product frozen, ClearA_loadB ignored.
      for (int k = 0; k < 5; k++) begin
        @(negedge Clk);
        bus8.ClearA_loadB = 1'b1;
        bus8.Din = 8'($urandom);
        checks++; if (bus8.Done !== 1'b1 || bus8.Busy !== 1'b0 || {bus8.Aval, bus8.Bval} !== exp) begin
          errors++; $display("FAIL b2b%0d_hold got done %b busy %b ab %h want 1 0 %h",
                             i, bus8.Done, bus8.Busy, {bus8.Aval, bus8.Bval}, exp);
        end
      end
      mb8 = exp[7:0];
      release8();
    end
  endtask

  task automatic test_both_high();
    logic [7:0] v;
    v = 8'($urandom);
    @(negedge Clk);
    bus8.ClearA_loadB = 1'b1;
    bus8.Execute      = 1'b1;
    bus8.Din          = v;
    repeat (2) begin
      @(negedge Clk);
      checks++; if (bus8.Busy !== 1'b0 || bus8.Bval !== v || bus8.Aval !== 8'h00 || bus8.X !== 1'b0) begin
        errors++; $display("FAIL both_high got busy %b b %h a %h x %b want 0 %h 00 0",
                           bus8.Busy, bus8.Bval, bus8.Aval, bus8.X, v);
      end
    end
    bus8.ClearA_loadB = 1'b0;
    bus8.Execute      = 1'b0;
    mb8 = v;
  endtask

  task automatic test_reset_mid();
    logic [7:0] a, b, din;
    logic x, done;
    logic [15:0] exp;
    int edges, busy_n;
    load8(8'hB7);
    @(negedge Clk);
    bus8.Din         = 8'h5C;
    bus8.Signed_mode = 1'b1;
    bus8.Execute     = 1'b1;
    repeat (8) @(posedge Clk);
    #2;
    checks++; if (bus8.Busy !== 1'b1) begin errors++; $display("FAIL mid_busy got %b want 1", bus8.Busy); end
    Reset = 1'b0;
    bus8.Execute = 1'b0;
    #1;
    checks++; if ({bus8.Aval, bus8.Bval, bus8.X, bus8.Busy, bus8.Done} !== 19'h0) begin
      errors++; $display("FAIL mid_reset got a %h b %h x %b busy %b done %b want all 0",
                         bus8.Aval, bus8.Bval, bus8.X, bus8.Busy, bus8.Done);
    end
    @(negedge Clk);
    Reset = 1'b1;
    mb8 = 8'h00;
    load8(8'h9A);
    din = 8'h3D;
    exp = 16'(ref_prod(8, longint'(mb8), longint'(din), 1'b0));
    run8(din, 1'b0, a, b, x, done, edges, busy_n);
    checks++; if ({a, b} !== exp || x !== 1'b0 || edges != Lat8) begin
      errors++; $display("FAIL post_reset got %h x %b lat %0d want %h 0 %0d", {a, b}, x, edges, exp, Lat8);
    end
    mb8 = exp[7:0];
    release8();
  endtask

  task automatic test_width16();
    logic [15:0] vb [4] = '{16'h8000, 16'h8000, 16'hFFFF, 16'h1234};
    logic [15:0] vs [4] = '{16'h7FFF, 16'h8000, 16'hFFFF, 16'hF00D};
    logic        sg [4] = '{1'b1, 1'b1, 1'b0, 1'b1};
    logic [31:0] exp;
    int edges;
    for (int i = 0; i < 4; i++) begin
      if (i == 3) vb[i] = 16'($urandom);
      exp = 32'(ref_prod(16, longint'(vb[i]), longint'(vs[i]), sg[i]));
      if (i == 0) begin
        checks++; if (exp !== 32'hC0008000) begin errors++; $display("FAIL w16_ref got %h want c0008000", exp); end
      end
      @(negedge Clk);
      bus16.ClearA_loadB = 1'b1;
      bus16.Din = vb[i];
      @(negedge Clk);
      bus16.ClearA_loadB = 1'b0;
      bus16.Din = vs[i];
      bus16.Signed_mode = sg[i];
      bus16.Execute = 1'b1;
      edges = 0;
      while (bus16.Done !== 1'b1 && edges < 100) begin
        @(posedge Clk);
        #1;
        edges++;
        bus16.Din = 16'($urandom);
      end
      checks++; if ({bus16.Aval, bus16.Bval} !== exp || bus16.X !== (sg[i] & exp[31])) begin
        errors++; $display("FAIL w16_%0d_prod got %h x %b want %h x %b", i,
                           {bus16.Aval, bus16.Bval}, bus16.X, exp, sg[i] & exp[31]);
      end
      checks++; if (edges != Lat16) begin errors++; $display("FAIL w16_%0d_latency got %0d want %0d", i, edges, Lat16); end
      @(negedge Clk);
      bus16.Execute = 1'b0;
      @(negedge Clk);
    end
  endtask

  initial begin
    bus8.ClearA_loadB  = 1'b0;
    bus8.Execute       = 1'b0;
    bus8.Signed_mode   = 1'b0;
    bus8.Din           = '0;
    bus16.ClearA_loadB = 1'b0;
    bus16.Execute      = 1'b0;
    bus16.Signed_mode  = 1'b0;
    bus16.Din          = '0;
    test_reset();
    test_directed();
    test_random();
    test_back_to_back();
    test_both_high();
    test_reset_mid();
    test_width16();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
